i2s_clock_gen: RTL and testbench
================================

I2S_CLOCK_GEN -- requirements
Module: i2s_clock_gen

Interface
REQ-001 SHALL have parameter SLOT_BITS, default 32, giving sclk periods per channel slot; frame = 2*SLOT_BITS sclk periods.
REQ-002 SHALL have parameter DIV_W, default 4, giving the width of the sclk divider setting.
REQ-003 SHALL have port mclk, input, 1, master clock; the only clock.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port en, input, 1, run request.
REQ-006 SHALL have port half_div, input, DIV_W, sclk half-period minus one, in mclk cycles.
REQ-007 SHALL have port dsp_mode, input, 1, lrclk format: 0 = 50% duty I2S/LJ; 1 = one-sclk frame-sync pulse.
REQ-008 SHALL have port sclk, output, 1, bit clock, registered.
REQ-009 SHALL have port lrclk, output, 1, word/frame clock, registered.
REQ-010 SHALL have port fall_stb, output, 1, one-mclk pulse in the cycle after sclk falls.
REQ-011 SHALL have port rise_stb, output, 1, one-mclk pulse in the cycle after sclk rises.
REQ-012 SHALL have port frame_stb, output, 1, one-mclk pulse in the cycle bit_idx becomes 0.
REQ-013 SHALL have port bit_idx, output, $clog2(2*SLOT_BITS), sclk period index within frame.
REQ-014 SHALL have port running, output, 1, high in RUN and DRAIN.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DRAIN.
REQ-016 SHALL, in IDLE with en=1, enter RUN on the next mclk edge; that edge SHALL load shadow D=half_div and dsp_mode, clear divider count and bit_idx, keep sclk=0, and pulse frame_stb.
REQ-017 SHALL, in RUN/DRAIN, increment divider count each mclk; when count==D it SHALL clear to 0 and toggle sclk, so each sclk half-period is exactly D+1 mclk cycles.
REQ-018 SHALL increment bit_idx on each sclk falling edge, wrapping 2*SLOT_BITS-1 -> 0; wrap SHALL pulse frame_stb.
REQ-019 SHALL, with dsp_mode=0, drive lrclk=0 for bit_idx < SLOT_BITS and 1 otherwise, changing only with sclk falling.
REQ-020 SHALL, with dsp_mode=1, drive lrclk=1 only while bit_idx==0.
REQ-021 SHALL reload shadow D and dsp_mode only on the edge where bit_idx wraps to 0; mid-frame input changes SHALL have no effect.
REQ-022 SHALL, in RUN with en=0, enter DRAIN; the frame in progress SHALL complete unmodified.
REQ-023 SHALL, in DRAIN at the bit_idx wrap edge, enter IDLE with sclk=0, lrclk=0, bit_idx=0, count=0, and no frame_stb pulse.
REQ-024 SHALL, in DRAIN with en=1, return to RUN with no disturbance of sclk, lrclk, bit_idx or divider count.
REQ-025 SHALL, with half_div=0, produce sclk=mclk/2 and strobes on every mclk cycle alternately (rise, fall).
REQ-026 SHALL hold all outputs constant in IDLE: sclk=0, lrclk=0, strobes=0, bit_idx=0, running=0.
REQ-027 SHALL drive fall_stb and rise_stb from the same edge that updates sclk; they SHALL never be high together.
REQ-028 SHALL drive running=1 from the edge entering RUN through the edge entering IDLE.

Reset
REQ-029 SHALL, on rst=1, immediately force state IDLE and all outputs and internal counters to 0, independent of mclk.
REQ-030 SHALL, on rst deassertion with en=1, start per REQ-016 on the first mclk edge after release.
REQ-031 SHALL abandon a frame in progress on rst mid-operation; no DRAIN.

Verification
REQ-032 SHALL check: defaults, half_div=3, dsp_mode=0, en=1 -> sclk = mclk/8; lrclk = mclk/512, low for 256 mclk cycles then high for 256; frame_stb every 512 mclk cycles.
REQ-033 SHALL check: dsp_mode=1, half_div=1 -> lrclk high for exactly 4 mclk cycles per 256; rise_stb/fall_stb alternate every 2 mclk cycles.
REQ-034 SHALL check: half_div changed 3->1 at bit_idx=10 -> period stays 8 mclk cycles until the frame wrap, then 4 mclk cycles.
REQ-035 SHALL check: en dropped at bit_idx=5 -> frame continues to bit_idx=63; IDLE at wrap with sclk=lrclk=0; en re-raised at bit_idx=40 -> no gap in sclk.
REQ-036 SHALL check: rst pulsed mid-frame (async, between mclk edges) -> all outputs 0 immediately; restart after release per REQ-030.
REQ-037 SHALL check: half_div=0 -> sclk toggles every mclk edge; bit_idx wraps every 128 mclk cycles.

Source files
------------

// File: rtl/i2s_clock_gen.sv
// I2S / DSP-mode bit and frame clock generator driven from a single master clock.
// Divider and format settings are captured per frame so mid-frame input changes never glitch the bus.
module i2s_clock_gen #(
    parameter int SLOT_BITS = 32,
    parameter int DIV_W     = 4
) (
    input  logic                              mclk,
    input  logic                              rst,
    input  logic                              en,
    input  logic [DIV_W-1:0]                  half_div,
    input  logic                              dsp_mode,
    output logic                              sclk,
    output logic                              lrclk,
    output logic                              fall_stb,
    output logic                              rise_stb,
    output logic                              frame_stb,
    output logic [$clog2(2*SLOT_BITS)-1:0]    bit_idx,
    output logic                              running
);

    localparam int BW = $clog2(2*SLOT_BITS);
    localparam logic [BW-1:0] LAST = BW'(2*SLOT_BITS-1);
    localparam logic [BW-1:0] SLOT = BW'(SLOT_BITS);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state, state_n;
    logic [DIV_W-1:0]   cnt, cnt_n;
    logic [DIV_W-1:0]   d_sh, d_n;
    logic               dsp_sh, dsp_n;
    logic               sclk_n, lr_n, fall_n, rise_n, frame_n;
    logic [BW-1:0]      bit_n;

    assign running = (state != IDLE);

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            d_sh      <= '0;
            dsp_sh    <= 1'b0;
            sclk      <= 1'b0;
            lrclk     <= 1'b0;
            fall_stb  <= 1'b0;
            rise_stb  <= 1'b0;
            frame_stb <= 1'b0;
            bit_idx   <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            d_sh      <= d_n;
            dsp_sh    <= dsp_n;
            sclk      <= sclk_n;
            lrclk     <= lr_n;
            fall_stb  <= fall_n;
            rise_stb  <= rise_n;
            frame_stb <= frame_n;
            bit_idx   <= bit_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        d_n     = d_sh;
        dsp_n   = dsp_sh;
        sclk_n  = sclk;
        lr_n    = lrclk;
        fall_n  = 1'b0;
        rise_n  = 1'b0;
        frame_n = 1'b0;
        bit_n   = bit_idx;
        case (state)
            IDLE: begin
                if (en) begin
                    state_n = RUN;
                    d_n     = half_div;
                    dsp_n   = dsp_mode;
                    cnt_n   = '0;
                    bit_n   = '0;
                    sclk_n  = 1'b0;
                    lr_n    = dsp_mode;
                    frame_n = 1'b1;
                end
            end
            default: begin
                state_n = en ? RUN : DRAIN;
                if (cnt == d_sh) begin
                    cnt_n  = '0;
                    sclk_n = ~sclk;
                    if (sclk) begin
                        if (bit_idx == LAST) begin
                            // Frame boundary: either stop cleanly or start the next frame with fresh settings.
                            if (state == DRAIN && !en) begin
                                state_n = IDLE;
                                sclk_n  = 1'b0;
                                lr_n    = 1'b0;
                                bit_n   = '0;
                            end else begin
                                fall_n  = 1'b1;
                                bit_n   = '0;
                                frame_n = 1'b1;
                                d_n     = half_div;
                                dsp_n   = dsp_mode;
                                lr_n    = dsp_mode;
                            end
                        end else begin
                            fall_n = 1'b1;
                            bit_n  = bit_idx + 1'b1;
                            lr_n   = dsp_sh ? 1'b0 : (bit_n >= SLOT);
                        end
                    end else begin
                        rise_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_i2s_clock_gen.sv
// Randomized scoreboard bench for i2s_clock_gen; the reference model tracks
// position within the current frame and derives every output arithmetically.
module tb_i2s_clock_gen;

    localparam int SLOT_BITS = 32;
    localparam int DIV_W     = 4;
    localparam int FBITS     = 2*SLOT_BITS;

    logic             mclk = 1'b0;
    logic             rst;
    logic             en;
    logic [DIV_W-1:0] half_div;
    logic             dsp_mode;
    logic             sclk, lrclk, fall_stb, rise_stb, frame_stb, running;
    logic [5:0]       bit_idx;

    i2s_clock_gen #(.SLOT_BITS(SLOT_BITS), .DIV_W(DIV_W)) dut (
        .mclk      (mclk),
        .rst       (rst),
        .en        (en),
        .half_div  (half_div),
        .dsp_mode  (dsp_mode),
        .sclk      (sclk),
        .lrclk     (lrclk),
        .fall_stb  (fall_stb),
        .rise_stb  (rise_stb),
        .frame_stb (frame_stb),
        .bit_idx   (bit_idx),
        .running   (running)
    );

    always #5 mclk = ~mclk;

    typedef struct packed {
        logic       sclk;
        logic       lrclk;
        logic       fall;
        logic       rise;
        logic       frame;
        logic [5:0] bidx;
        logic       running;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: active flag, drain flag, mclk edges since frame start, frame settings.
    bit   m_active = 1'b0;
    bit   m_drain  = 1'b0;
    int   fpos     = 0;
    int   fd       = 0;
    bit   fdsp     = 1'b0;

    task automatic model_edge();
        obs_t e;
        int   flen;
        int   half;
        bit   toggle;
        e = '0;
        if (rst) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (en) begin
                m_active = 1'b1;
                m_drain  = 1'b0;
                fpos     = 0;
                fd       = int'(half_div);
                fdsp     = dsp_mode;
                e.lrclk  = fdsp;
                e.frame  = 1'b1;
                e.running = 1'b1;
            end
        end else begin
            flen   = 2*FBITS*(fd+1);
            fpos   = fpos + 1;
            toggle = (fpos % (fd+1)) == 0;
            half   = fpos / (fd+1);
            if (fpos == flen && m_drain && !en) begin
                m_active = 1'b0;
            end else begin
                e.sclk = (half % 2) == 1;
                e.fall = toggle && ((half % 2) == 0);
                e.rise = toggle && ((half % 2) == 1);
                if (fpos == flen) begin
                    fpos    = 0;
                    half    = 0;
                    fd      = int'(half_div);
                    fdsp    = dsp_mode;
                    e.frame = 1'b1;
                end
                e.bidx    = 6'((half / 2) % FBITS);
                e.lrclk   = fdsp ? (e.bidx == 6'd0) : (int'(e.bidx) >= SLOT_BITS);
                e.running = 1'b1;
                m_drain   = !en;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge mclk);
            model_edge();
            #2;
        end
    endtask

    task automatic check_zero(input string name);
        obs_t a;
        a = {sclk, lrclk, fall_stb, rise_stb, frame_stb, bit_idx, running};
        checks++;
        if (a !== '0) begin
            errors++;
            $display("FAIL %s: outputs=%h required 0", name, a);
        end
    endtask

    task automatic async_reset(input logic en_after);
        @(negedge mclk);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        tick(1);
        rst = 1'b0;
        en  = en_after;
    endtask

    always @(negedge mclk) begin : monitor
        obs_t e;
        obs_t a;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {sclk, lrclk, fall_stb, rise_stb, frame_stb, bit_idx, running};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs @%0t: got sclk=%b lr=%b fall=%b rise=%b frame=%b bit=%0d run=%b, required sclk=%b lr=%b fall=%b rise=%b frame=%b bit=%0d run=%b",
                         $time, a.sclk, a.lrclk, a.fall, a.rise, a.frame, a.bidx, a.running,
                         e.sclk, e.lrclk, e.fall, e.rise, e.frame, e.bidx, e.running);
            end
        end
    end

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        half_div = 4'd3;
        dsp_mode = 1'b0;
        #1;
        check_zero("reset_state");
        tick(3);
        rst = 1'b0;
        tick(4);

        // mclk/8 bit clock, 512-cycle LJ frames
        en = 1'b1;
        tick(1100);

        // DSP frame sync, half_div=1
        async_reset(1'b1);
        half_div = 4'd1;
        dsp_mode = 1'b1;
        tick(600);

        // divider change mid-frame takes effect at the next wrap
        async_reset(1'b1);
        half_div = 4'd3;
        dsp_mode = 1'b0;
        tick(1 + 80 + $urandom_range(0, 7));
        half_div = 4'd1;
        tick(1000);

        // drain, re-raise mid-drain, then drain to idle
        async_reset(1'b1);
        half_div = 4'd3;
        tick(1 + 40 + $urandom_range(0, 7));
        en = 1'b0;
        tick(280);
        en = 1'b1;
        tick(200);
        en = 1'b0;
        tick(1100);

        // fastest bit clock
        half_div = 4'd0;
        en = 1'b1;
        tick(300);

        // randomized run with settings, enable and reset changes
        for (int i = 0; i < 40; i++) begin
            en       = ($urandom_range(0, 3) != 0);
            half_div = DIV_W'($urandom_range(0, 3));
            dsp_mode = 1'($urandom_range(0, 1));
            tick($urandom_range(20, 400));
            if ($urandom_range(0, 9) == 0)
                async_reset(1'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge mclk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending=%0d required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
